// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 64-block x 32-bit data memory.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_direct_mapped #(
   parameter int INDEX_BITS = 3,
   parameter int STAT_WIDTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [7:0]  address,
   input  logic [7:0]  writedata,
   output logic [7:0]  readdata,
   output logic        busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [5:0]  mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] hit_count,
   output logic [STAT_WIDTH-1:0] miss_count
`endif
);

   localparam int TAG_BITS = 6 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_e;

   state_e                 state_q;
   logic [LINES-1:0]       valid_q;
   logic [LINES-1:0]       dirty_q;
   logic [TAG_BITS-1:0]    tag_q  [LINES];
   logic [31:0]            data_q [LINES];
   logic [INDEX_BITS-1:0]  missIndex_q;
   logic [TAG_BITS-1:0]    missTag_q;
   logic [31:0]            fillData_q;
   logic                   firstCycle_q;
   logic                   mem_read_q;
   logic                   mem_write_q;
   logic [5:0]             mem_address_q;
   logic [31:0]            mem_writedata_q;

   logic [1:0]             offset;
   logic [INDEX_BITS-1:0]  reqIndex;
   logic [TAG_BITS-1:0]    reqTag;
   logic                   rdReq;
   logic                   wrReq;
   logic                   hit;
   logic [31:0]            curBlock;
   logic [31:0]            storeBlock_d;

   // Simultaneous read and write is illegal and is ignored as a request.
   assign offset   = address[1:0];
   assign reqIndex = address[INDEX_BITS+1:2];
   assign reqTag   = address[7:INDEX_BITS+2];
   assign rdReq    = read & ~write;
   assign wrReq    = write & ~read;
   assign hit      = valid_q[reqIndex] && (tag_q[reqIndex] == reqTag);
   assign curBlock = data_q[reqIndex];

   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_address   = mem_address_q;
   assign mem_writedata = mem_writedata_q;

   always_comb begin
      busywait     = 1'b1;
      readdata     = 8'h00;
      storeBlock_d = curBlock;
      storeBlock_d[{offset, 3'b000} +: 8] = writedata;
      if (state_q == IDLE) begin
         busywait = (rdReq || wrReq) && !hit;
         if (rdReq && hit) begin
            readdata = curBlock[{offset, 3'b000} +: 8];
         end
      end
   end

   // Control FSM; memory-side outputs are registered and change only on state transitions.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q         <= IDLE;
         valid_q         <= '0;
         dirty_q         <= '0;
         missIndex_q     <= '0;
         missTag_q       <= '0;
         fillData_q      <= '0;
         firstCycle_q    <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wrReq && hit) begin
                  dirty_q[reqIndex] <= 1'b1;
               end else if ((rdReq || wrReq) && !hit) begin
                  missIndex_q  <= reqIndex;
                  missTag_q    <= reqTag;
                  firstCycle_q <= 1'b1;
                  if (valid_q[reqIndex] && dirty_q[reqIndex]) begin
                     state_q         <= WRITEBACK;
                     mem_write_q     <= 1'b1;
                     mem_address_q   <= {tag_q[reqIndex], reqIndex};
                     mem_writedata_q <= curBlock;
                  end else begin
                     state_q       <= FETCH;
                     mem_read_q    <= 1'b1;
                     mem_address_q <= {reqTag, reqIndex};
                  end
               end
            end
            // The memory may not have raised its busy flag yet in the first cycle of a request.
            WRITEBACK: begin
               if (firstCycle_q) begin
                  firstCycle_q <= 1'b0;
               end else if (!mem_busywait) begin
                  state_q         <= FETCH;
                  firstCycle_q    <= 1'b1;
                  mem_write_q     <= 1'b0;
                  mem_writedata_q <= '0;
                  mem_read_q      <= 1'b1;
                  mem_address_q   <= {missTag_q, missIndex_q};
               end
            end
            FETCH: begin
               if (firstCycle_q) begin
                  firstCycle_q <= 1'b0;
               end else if (!mem_busywait) begin
                  state_q       <= FILL;
                  fillData_q    <= mem_readdata;
                  mem_read_q    <= 1'b0;
                  mem_address_q <= '0;
               end
            end
            FILL: begin
               valid_q[missIndex_q] <= 1'b1;
               dirty_q[missIndex_q] <= 1'b0;
               state_q              <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; the cleared valid bits hide their contents.
   always_ff @(posedge clock) begin
      if (state_q == IDLE && wrReq && hit) begin
         data_q[reqIndex] <= storeBlock_d;
      end else if (state_q == FILL) begin
         data_q[missIndex_q] <= fillData_q;
         tag_q[missIndex_q]  <= missTag_q;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [STAT_WIDTH-1:0] hitCount_q;
   logic [STAT_WIDTH-1:0] missCount_q;
   logic                  postFill_q;

   // The hit that follows a fill belongs to the miss already counted, so it is skipped.
   always_ff @(posedge clock) begin
      if (!reset) begin
         hitCount_q  <= '0;
         missCount_q <= '0;
         postFill_q  <= 1'b0;
      end else begin
         postFill_q <= (state_q == FILL);
         if (state_q == IDLE && (rdReq || wrReq) && hit && !postFill_q && hitCount_q != '1) begin
            hitCount_q <= hitCount_q + 1'b1;
         end
         if (state_q == IDLE && (rdReq || wrReq) && !hit && missCount_q != '1) begin
            missCount_q <= missCount_q + 1'b1;
         end
      end
   end

   assign hit_count  = hitCount_q;
   assign miss_count = missCount_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
